io_sig_checker: RTL and testbench

IO_SIG_CHECKER -- requirements
Module: io_sig_checker

---
 rtl/io_sig_pkg.sv | 18 +
 rtl/io_sig_fifo.sv | 82 ++++++++
 rtl/io_sig_checker.sv | 175 +++++++++++++++++
 tb/tb_io_sig_checker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_sig_pkg.sv
// Shared types for the io signature checker: run-state encoding and fail codes.
package io_sig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } io_sig_state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_TIMEOUT = 2'd1,
        FC_EMPTY   = 2'd2,
        FC_ABORT   = 2'd3
    } io_sig_fail_e;

endpackage

// File: rtl/io_sig_fifo.sv
// Expected-entry FIFO holding (data, mask) pairs; the head is presented combinationally.
module io_sig_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [WIDTH-1:0]       wr_mask,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       head_data,
    output logic [WIDTH-1:0]       head_mask,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] data_mem_q [DEPTH];
    logic [WIDTH-1:0] mask_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count_q == CW'(DEPTH));
    assign do_wr = wr_en && !full && !clr;
    assign do_rd = rd_en && (count_q != '0) && !clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty count makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            data_mem_q[wr_ptr_q] <= wr_data;
            mask_mem_q[wr_ptr_q] <= wr_mask;
        end
    end

    assign head_data = data_mem_q[rd_ptr_q];
    assign head_mask = mask_mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/io_sig_checker.sv
// Watches synchronized pad inputs against a loaded sequence of masked expected values,
// each of which must hold for STABLE cycles before its per-step timeout expires.
module io_sig_checker
    import io_sig_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int TMO_W  = 16,
    parameter int STABLE = 2
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [WIDTH-1:0]       ld_data,
    input  logic [WIDTH-1:0]       ld_mask,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   clear,
    input  logic [TMO_W-1:0]       timeout,
    input  logic [WIDTH-1:0]       io_in,
    output logic                   busy,
    output logic                   pass,
    output logic                   fail,
    output logic [1:0]             fail_code,
    output logic [WIDTH-1:0]       fail_value,
    output logic [$clog2(DEPTH):0] step,
    output io_sig_state_e          dbg_state
);

    localparam int SW  = $clog2(DEPTH) + 1;
    localparam int STW = $clog2(STABLE + 1);
    localparam logic [STW-1:0] STABLE_LAST = STW'(STABLE - 1);

    // Load handshake: an entry transfers on any edge where ld_valid && ld_ready,
    // unless clear is high in that cycle; ld_ready never depends on ld_valid.

    logic [WIDTH-1:0] sync1_q, sync2_q;

    io_sig_state_e    state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic [STW-1:0]   stable_q, stable_d;
    io_sig_fail_e     fail_code_q, fail_code_d;
    logic [WIDTH-1:0] fail_value_q, fail_value_d;

    logic [WIDTH-1:0] head_data;
    logic [WIDTH-1:0] head_mask;
    logic [SW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_rd;
    logic             load_fire;
    logic             head_match;
    logic             tmo_hit;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= io_in;
            sync2_q <= sync1_q;
        end
    end

    assign ld_ready   = (state_q == ST_IDLE) && !fifo_full;
    assign load_fire  = ld_valid && ld_ready && !clear;
    assign head_match = ((sync2_q & head_mask) == (head_data & head_mask));
    assign tmo_hit    = (timeout != '0) && (timer_q == timeout - TMO_W'(1));

    io_sig_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (resetb),
        .clr       (clear),
        .wr_en     (load_fire),
        .wr_data   (ld_data),
        .wr_mask   (ld_mask),
        .rd_en     (fifo_rd),
        .head_data (head_data),
        .head_mask (head_mask),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        timer_d      = timer_q;
        stable_d     = stable_q;
        fail_code_d  = fail_code_q;
        fail_value_d = fail_value_q;
        fifo_rd      = 1'b0;

        if (clear) begin
            state_d      = ST_IDLE;
            step_d       = '0;
            timer_d      = '0;
            stable_d     = '0;
            fail_code_d  = FC_NONE;
            fail_value_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        timer_d  = '0;
                        stable_d = '0;
                        // An entry accepted on the start edge counts as loaded.
                        if ((fifo_count != '0) || load_fire) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d     = ST_FAIL;
                            fail_code_d = FC_EMPTY;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_d     = ST_FAIL;
                        fail_code_d = FC_ABORT;
                    end else if (head_match && (stable_q == STABLE_LAST)) begin
                        // Completing a step wins over a timeout in the same cycle.
                        fifo_rd  = 1'b1;
                        step_d   = step_q + SW'(1);
                        stable_d = '0;
                        timer_d  = '0;
                        if (fifo_count == SW'(1)) begin
                            state_d = ST_PASS;
                        end
                    end else begin
                        stable_d = head_match ? (stable_q + STW'(1)) : '0;
                        timer_d  = timer_q + TMO_W'(1);
                        if (tmo_hit) begin
                            state_d      = ST_FAIL;
                            fail_code_d  = FC_TIMEOUT;
                            fail_value_d = sync2_q;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            timer_q      <= '0;
            stable_q     <= '0;
            fail_code_q  <= FC_NONE;
            fail_value_q <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            timer_q      <= timer_d;
            stable_q     <= stable_d;
            fail_code_q  <= fail_code_d;
            fail_value_q <= fail_value_d;
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign pass       = (state_q == ST_PASS);
    assign fail       = (state_q == ST_FAIL);
    assign fail_code  = fail_code_q;
    assign fail_value = fail_value_q;
    assign step       = step_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_io_sig_checker.sv
// Directed bench for io_sig_checker: outcomes queued as stimulus is driven, compared on completion.
module tb_io_sig_checker;
    import io_sig_pkg::*;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int TW = 16;
    localparam int ST = 2;
    localparam int SW = $clog2(D) + 1;

    logic          clock = 1'b0;
    logic          resetb;
    logic          ld_valid;
    logic          ld_ready;
    logic [W-1:0]  ld_data;
    logic [W-1:0]  ld_mask;
    logic          start;
    logic          abort;
    logic          clear;
    logic [TW-1:0] timeout;
    logic [W-1:0]  io_in;
    logic          busy;
    logic          pass;
    logic          fail;
    logic [1:0]    fail_code;
    logic [W-1:0]  fail_value;
    logic [SW-1:0] step;
    io_sig_state_e dbg_state;

    int errors = 0;
    int checks = 0;

    // {pass, fail, fail_code, step, fail_value}
    logic [23:0] exp_q[$];

    io_sig_checker #(
        .WIDTH  (W),
        .DEPTH  (D),
        .TMO_W  (TW),
        .STABLE (ST)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_mask    (ld_mask),
        .start      (start),
        .abort      (abort),
        .clear      (clear),
        .timeout    (timeout),
        .io_in      (io_in),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .fail_code  (fail_code),
        .fail_value (fail_value),
        .step       (step),
        .dbg_state  (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] outcome(input logic p, input logic f, input logic [1:0] c,
                                            input logic [SW-1:0] s, input logic [W-1:0] v);
        return {p, f, c, s, v};
    endfunction

    task automatic pop_check(input string tag);
        logic [23:0] exp;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            chk(tag, 32'({pass, fail, fail_code, step, fail_value}), 32'(exp));
        end
    endtask

    task automatic load(input logic [W-1:0] d, input logic [W-1:0] m);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_mask  = m;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_bound"}, 32'(busy), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_status"}, 32'({pass, fail, fail_code, step, fail_value}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [W-1:0] rm;

        resetb   = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_mask  = '0;
        start    = 1'b0;
        abort    = 1'b0;
        clear    = 1'b0;
        timeout  = '0;
        io_in    = '0;
        #12;
        check_idle("reset");
        resetb = 1'b1;
        tick();

        // Two-entry sequence with the exact io timing from the requirement.
        load(16'h00A5, 16'h00FF);
        load(16'h5A00, 16'hFF00);
        exp_q.push_back(outcome(1'b1, 1'b0, 2'd0, SW'(2), '0));
        io_in = 16'h12A5;
        do_start();
        chk("seq_busy", 32'(busy), 32'd1);
        tick();
        io_in = 16'h5A34;
        tick();
        tick();
        io_in = '0;
        wait_done("seq", 20);
        pop_check("seq_pass");
        do_clear();
        check_idle("seq_clear");

        // Timeout of 10 with io stuck low: fail lands on the 10th RUN cycle.
        load(16'h0001, 16'h0001);
        timeout = TW'(10);
        do_start();
        repeat (9) tick();
        chk("tmo_still_busy", 32'(busy), 32'd1);
        exp_q.push_back(outcome(1'b0, 1'b1, 2'd1, '0, '0));
        tick();
        pop_check("tmo_fail");
        exp_q.push_back(outcome(1'b0, 1'b1, 2'd1, '0, '0));
        repeat (3) tick();
        pop_check("tmo_hold");
        do_clear();
        timeout = '0;

        // Match 1, mismatch 1, match 2: only the final pair completes the step.
        load(16'h0033, 16'h00FF);
        do_start();
        tick();
        tick();
        exp_q.push_back(outcome(1'b1, 1'b0, 2'd0, SW'(1), '0));
        io_in = 16'hAB33;
        tick();
        io_in = 16'h0000;
        tick();
        io_in = 16'h1233;
        tick();
        tick();
        io_in = '0;
        tick();
        chk("stab_not_yet_busy", 32'(busy), 32'd1);
        chk("stab_not_yet_step", 32'(step), 32'd0);
        tick();
        pop_check("stab_pass");
        do_clear();

        // Start on an empty FIFO; abort and start are ignored once failed.
        exp_q.push_back(outcome(1'b0, 1'b1, 2'd2, '0, '0));
        do_start();
        pop_check("empty_fail");
        chk("empty_ld_ready", 32'(ld_ready), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        do_start();
        exp_q.push_back(outcome(1'b0, 1'b1, 2'd2, '0, '0));
        pop_check("empty_hold");
        do_clear();

        // Start together with the only load; then abort the run.
        ld_valid = 1'b1;
        ld_data  = 16'hFFFF;
        ld_mask  = 16'hFFFF;
        start    = 1'b1;
        tick();
        ld_valid = 1'b0;
        start    = 1'b0;
        chk("simul_busy", 32'(busy), 32'd1);
        chk("simul_ld_ready", 32'(ld_ready), 32'd0);
        exp_q.push_back(outcome(1'b0, 1'b1, 2'd3, '0, '0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pop_check("simul_abort");
        do_clear();

        // Fill the FIFO, run, abort, then clear back to idle.
        for (int i = 0; i < D; i++) begin
            load(W'($urandom_range(1, 16'hFFFF)), 16'hFFFF);
        end
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        do_start();
        repeat (3) tick();
        chk("full_busy", 32'(busy), 32'd1);
        exp_q.push_back(outcome(1'b0, 1'b1, 2'd3, '0, '0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pop_check("full_abort");
        do_clear();
        check_idle("full_clear");

        // Clear wins over a same-cycle load and start; FIFO ends up empty.
        load(16'h1234, 16'hFFFF);
        clear    = 1'b1;
        ld_valid = 1'b1;
        start    = 1'b1;
        tick();
        clear    = 1'b0;
        ld_valid = 1'b0;
        start    = 1'b0;
        check_idle("clr_prio");
        exp_q.push_back(outcome(1'b0, 1'b1, 2'd2, '0, '0));
        do_start();
        pop_check("clr_flushed");
        do_clear();

        // Random single-entry runs exercising the mask.
        for (int k = 0; k < 4; k++) begin
            rd = W'($urandom_range(0, 16'hFFFF));
            rm = W'($urandom_range(1, 16'hFFFF));
            load(rd, rm);
            io_in = (rd & rm) | (~rm & W'($urandom_range(0, 16'hFFFF)));
            exp_q.push_back(outcome(1'b1, 1'b0, 2'd0, SW'(1), '0));
            do_start();
            wait_done("rnd", 10);
            pop_check("rnd_pass");
            io_in = '0;
            do_clear();
        end

        // Reset mid-run clears everything without a clock edge.
        load(16'hFFFF, 16'hFFFF);
        timeout = TW'(1000);
        do_start();
        repeat (2) tick();
        chk("rst_pre_busy", 32'(busy), 32'd1);
        resetb = 1'b0;
        #2;
        check_idle("rst_async");
        resetb = 1'b1;
        timeout = '0;
        tick();
        exp_q.push_back(outcome(1'b0, 1'b1, 2'd2, '0, '0));
        do_start();
        pop_check("rst_fifo_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
